// File: rtl/post_led_shifter_pkg.sv
// post_led_shifter_pkg
//   Shared definitions for the serial LED chain drivers: FSM state encoding,
//   default chain/timing constants and a counter-width helper.
package post_led_shifter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_SHIFT_LO    = 3'd1,
      ST_SHIFT_HI    = 3'd2,
      ST_LATCH_SETUP = 3'd3,
      ST_LATCH       = 3'd4
   } state_t;

   localparam int unsigned DEF_CHAIN_BITS     = 8;
   localparam int unsigned DEF_CLK_DIV        = 4;
   localparam int unsigned DEF_REFRESH_CYCLES = 1000000;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/post_led_tick_div.sv
// post_led_tick_div
//   Reloading down-counter that flags the last cycle of each PERIOD-cycle
//   window. PERIOD = 0 disables the terminal-count flag entirely.
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset (counter at start of window)
//   i_restart  start a new window next cycle
//   o_tc       high in the last cycle of the current window
module post_led_tick_div
   import post_led_shifter_pkg::*;
#(
   parameter int unsigned PERIOD = DEF_CLK_DIV
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   output logic o_tc
);

   localparam int unsigned LOAD = (PERIOD == 0) ? 0 : PERIOD - 1;
   localparam int unsigned W    = cnt_width(PERIOD);

   logic [W-1:0] r_cnt;

   // Remaining cycles in the window; reaching zero auto-reloads so the
   // counter free-runs between restarts.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_restart || (r_cnt == '0)) begin
         r_cnt <= W'(LOAD);
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tc = (PERIOD != 0) && (r_cnt == '0);

endmodule

// File: rtl/post_led_shifter.sv
// post_led_shifter
//   Serializes the active-low LED byte into a 74HC595-style chain. A frame is
//   sent on pattern change, periodic refresh or forced request; the chain
//   output-enable stays off until the first frame has been latched.
// Ports:
//   i_sys_clk        system clock
//   i_sys_rst        synchronous active-high reset
//   i_led_n          LED pattern (active-low), CHAIN_BITS wide
//   i_force_refresh  one-cycle request for a frame
//   o_sr_clk         chain shift clock
//   o_sr_data        chain serial data, MSB first
//   o_sr_latch       chain storage latch strobe
//   o_sr_oe_n        chain output enable, active-low
//   o_busy           frame in progress
//   o_frame_done     one-cycle pulse at frame completion
//
// state       | meaning
// ST_IDLE     | waiting for a trigger
// ST_SHIFT_LO | sr_clk low, current bit presented on sr_data
// ST_SHIFT_HI | sr_clk high, chain samples the bit
// ST_LATCH_SETUP | clock and data low before the latch strobe
// ST_LATCH    | storage latch strobe high
module post_led_shifter
   import post_led_shifter_pkg::*;
#(
   parameter int unsigned CHAIN_BITS     = DEF_CHAIN_BITS,
   parameter int unsigned CLK_DIV        = DEF_CLK_DIV,
   parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   input  logic [CHAIN_BITS-1:0] i_led_n,
   input  logic                  i_force_refresh,
   output logic                  o_sr_clk,
   output logic                  o_sr_data,
   output logic                  o_sr_latch,
   output logic                  o_sr_oe_n,
   output logic                  o_busy,
   output logic                  o_frame_done
);

   localparam int unsigned BW = cnt_width(CHAIN_BITS);

   state_t                r_state;
   state_t                w_state_next;
   logic [CHAIN_BITS-1:0] r_shift;
   logic [CHAIN_BITS-1:0] r_last_sent;
   logic                  r_pending;
   logic [BW-1:0]         r_bit_idx;
   logic                  r_sr_clk;
   logic                  r_sr_latch;
   logic                  r_sr_oe_n;
   logic                  r_busy;
   logic                  r_frame_done;

   logic w_phase_tc;
   logic w_refresh_tc;
   logic w_led_diff;
   logic w_trig;
   logic w_start;
   logic w_frame_end;

   // Phase timer is held loaded in IDLE so every frame state gets exactly
   // CLK_DIV cycles; it reloads itself at each state boundary.
   post_led_tick_div #(.PERIOD(CLK_DIV)) u_phase (
      .i_clk     (i_sys_clk),
      .i_rst     (i_sys_rst),
      .i_restart (r_state == ST_IDLE),
      .o_tc      (w_phase_tc)
   );

   post_led_tick_div #(.PERIOD(REFRESH_CYCLES)) u_refresh (
      .i_clk     (i_sys_clk),
      .i_rst     (i_sys_rst),
      .i_restart (w_start),
      .o_tc      (w_refresh_tc)
   );

   assign w_led_diff  = (i_led_n != r_last_sent);
   assign w_trig      = r_pending | i_force_refresh | w_led_diff | w_refresh_tc;
   assign w_start     = (r_state == ST_IDLE) && w_trig;
   assign w_frame_end = (r_state == ST_LATCH) && w_phase_tc;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:        if (w_trig)     w_state_next = ST_SHIFT_LO;
         ST_SHIFT_LO:    if (w_phase_tc) w_state_next = ST_SHIFT_HI;
         ST_SHIFT_HI:    if (w_phase_tc) w_state_next = (r_bit_idx == '0) ? ST_LATCH_SETUP : ST_SHIFT_LO;
         ST_LATCH_SETUP: if (w_phase_tc) w_state_next = ST_LATCH;
         ST_LATCH:       if (w_phase_tc) w_state_next = ST_IDLE;
         default:        w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_last_sent  <= '1;
         r_pending    <= 1'b1;
         r_bit_idx    <= '0;
         r_sr_clk     <= 1'b0;
         r_sr_latch   <= 1'b0;
         r_sr_oe_n    <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state <= w_state_next;

         if (w_start) begin
            r_shift     <= i_led_n;
            r_last_sent <= i_led_n;
            r_pending   <= 1'b0;
            r_bit_idx   <= BW'(CHAIN_BITS - 1);
         end else if ((r_state != ST_IDLE) && (i_force_refresh || w_led_diff)) begin
            r_pending <= 1'b1;
         end

         // Shifting zeros in leaves sr_data low after the last bit, which is
         // what LATCH_SETUP and IDLE need.
         if ((r_state == ST_SHIFT_HI) && w_phase_tc) begin
            r_shift <= r_shift << 1;
            if (r_bit_idx != '0) begin
               r_bit_idx <= r_bit_idx - 1'b1;
            end
         end

         // Outputs are decoded from the next state so they line up with it.
         r_sr_clk     <= (w_state_next == ST_SHIFT_HI);
         r_sr_latch   <= (w_state_next == ST_LATCH);
         r_busy       <= (w_state_next != ST_IDLE);
         r_frame_done <= w_frame_end;
         if (w_frame_end) begin
            r_sr_oe_n <= 1'b0;
         end
      end
   end

   assign o_sr_clk     = r_sr_clk;
   assign o_sr_data    = r_shift[CHAIN_BITS-1];
   assign o_sr_latch   = r_sr_latch;
   assign o_sr_oe_n    = r_sr_oe_n;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_post_led_shifter.sv
module tb_post_led_shifter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // DUT A: defaults
   logic       rst_a = 1'b1, frc_a = 1'b0;
   logic [7:0] led_a = 8'hA5;
   logic       sck_a, sdat_a, lat_a, oen_a, busy_a, done_a;
   // DUT B: 200-cycle refresh
   logic       rst_b = 1'b1, frc_b = 1'b0;
   logic [7:0] led_b = 8'h55;
   logic       sck_b, sdat_b, lat_b, oen_b, busy_b, done_b;
   // DUT C: 16-bit chain, CLK_DIV = 1
   logic        rst_c = 1'b1, frc_c = 1'b0;
   logic [15:0] led_c = 16'h8001;
   logic        sck_c, sdat_c, lat_c, oen_c, busy_c, done_c;

   post_led_shifter u_dut_a (
      .i_sys_clk(clk), .i_sys_rst(rst_a), .i_led_n(led_a), .i_force_refresh(frc_a),
      .o_sr_clk(sck_a), .o_sr_data(sdat_a), .o_sr_latch(lat_a), .o_sr_oe_n(oen_a),
      .o_busy(busy_a), .o_frame_done(done_a));

   post_led_shifter #(.REFRESH_CYCLES(200)) u_dut_b (
      .i_sys_clk(clk), .i_sys_rst(rst_b), .i_led_n(led_b), .i_force_refresh(frc_b),
      .o_sr_clk(sck_b), .o_sr_data(sdat_b), .o_sr_latch(lat_b), .o_sr_oe_n(oen_b),
      .o_busy(busy_b), .o_frame_done(done_b));

   post_led_shifter #(.CHAIN_BITS(16), .CLK_DIV(1)) u_dut_c (
      .i_sys_clk(clk), .i_sys_rst(rst_c), .i_led_n(led_c), .i_force_refresh(frc_c),
      .o_sr_clk(sck_c), .o_sr_data(sdat_c), .o_sr_latch(lat_c), .o_sr_oe_n(oen_c),
      .o_busy(busy_c), .o_frame_done(done_c));

   // Scoreboard: expected bits pushed with stimulus, observed bits captured
   // at each sr_clk rise.
   logic exp_a[$], obs_a[$], exp_c[$], obs_c[$];
   logic prev_sck_a = 1'b0, prev_sck_c = 1'b0;

   always @(negedge clk) begin
      if (sck_a && !prev_sck_a) obs_a.push_back(sdat_a);
      if (sck_c && !prev_sck_c) obs_c.push_back(sdat_c);
      prev_sck_a = sck_a;
      prev_sck_c = sck_c;
   end

   task automatic push_exp_a(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) exp_a.push_back(v[i]);
   endtask

   task automatic push_exp_c(input logic [15:0] v);
      for (int i = 15; i >= 0; i--) exp_c.push_back(v[i]);
   endtask

   task automatic test_reset();
      rst_a = 1'b1; led_a = 8'hA5; frc_a = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sck_a, sdat_a, lat_a, oen_a, busy_a, done_a} !== 6'b000100)
         $display("FAIL reset_outputs: got %b want 000100", {sck_a, sdat_a, lat_a, oen_a, busy_a, done_a});
      else n_pass++;
   endtask

   task automatic test_first_frame();
      int first_busy = -1, n_busy = 0, n_latch = 0, last_latch = -1, done_at = -1;
      logic oe_bad = 1'b0, oe_at_done = 1'b1, lat_at_done = 1'b1;
      logic e, o;
      exp_a.delete(); obs_a.delete();
      push_exp_a(8'hA5);
      rst_a = 1'b0;
      for (int k = 1; k <= 120; k++) begin
         @(negedge clk);
         if (busy_a) begin n_busy++; if (first_busy < 0) first_busy = k; end
         if (lat_a) begin n_latch++; last_latch = k; end
         if (done_a && done_at < 0) begin done_at = k; oe_at_done = oen_a; lat_at_done = lat_a; end
         if (done_at < 0 && !oen_a) oe_bad = 1'b1;
      end
      n_checks++; if (first_busy !== 1) $display("FAIL first_busy_start: got %0d want 1", first_busy); else n_pass++;
      n_checks++; if (n_busy !== 72) $display("FAIL first_busy_len: got %0d want 72", n_busy); else n_pass++;
      n_checks++; if (n_latch !== 4) $display("FAIL first_latch_len: got %0d want 4", n_latch); else n_pass++;
      n_checks++; if (last_latch !== 72) $display("FAIL first_latch_end: got %0d want 72", last_latch); else n_pass++;
      n_checks++; if (done_at !== 73) $display("FAIL first_done_at: got %0d want 73", done_at); else n_pass++;
      n_checks++; if ({oe_at_done, lat_at_done} !== 2'b00) $display("FAIL first_done_oe_latch: got %b want 00", {oe_at_done, lat_at_done}); else n_pass++;
      n_checks++; if (oe_bad !== 1'b0) $display("FAIL first_oe_early: got %b want 0", oe_bad); else n_pass++;
      n_checks++; if (oen_a !== 1'b0) $display("FAIL first_oe_after: got %b want 0", oen_a); else n_pass++;
      n_checks++;
      if (obs_a.size() != exp_a.size()) $display("FAIL first_bit_count: got %0d want %0d", obs_a.size(), exp_a.size());
      else n_pass++;
      while (exp_a.size() > 0) begin
         e = exp_a.pop_front();
         o = 1'bx; if (obs_a.size() > 0) o = obs_a.pop_front();
         n_checks++; if (o !== e) $display("FAIL first_bit: got %b want %b", o, e); else n_pass++;
      end
      obs_a.delete();
   endtask

   task automatic test_idle_change();
      int n_busy = 0, n_done = 0;
      logic e, o;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (busy_a) n_busy++;
      end
      n_checks++; if (n_busy !== 0) $display("FAIL idle_no_frame: got %0d busy cycles want 0", n_busy); else n_pass++;
      exp_a.delete(); obs_a.delete();
      push_exp_a(8'h3C);
      led_a = 8'h3C;
      @(negedge clk);
      n_checks++; if (busy_a !== 1'b1) $display("FAIL change_start: got busy %b want 1", busy_a); else n_pass++;
      n_busy = 1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (busy_a) n_busy++;
         if (done_a) n_done++;
      end
      n_checks++; if (n_done !== 1) $display("FAIL change_frames: got %0d want 1", n_done); else n_pass++;
      n_checks++; if (n_busy !== 72) $display("FAIL change_busy_len: got %0d want 72", n_busy); else n_pass++;
      n_checks++;
      if (obs_a.size() != exp_a.size()) $display("FAIL change_bit_count: got %0d want %0d", obs_a.size(), exp_a.size());
      else n_pass++;
      while (exp_a.size() > 0) begin
         e = exp_a.pop_front();
         o = 1'bx; if (obs_a.size() > 0) o = obs_a.pop_front();
         n_checks++; if (o !== e) $display("FAIL change_bit: got %b want %b", o, e); else n_pass++;
      end
      obs_a.delete();
   endtask

   task automatic test_back_to_back();
      int n_done = 0, done1 = -1, done2 = -1;
      logic busy_after = 1'b0;
      logic e, o;
      exp_a.delete(); obs_a.delete();
      push_exp_a(8'h01);
      push_exp_a(8'hFF);
      led_a = 8'h01;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (done1 >= 0 && k == done1 + 1) busy_after = busy_a;
         if (done_a) begin
            n_done++;
            if (done1 < 0) done1 = k; else if (done2 < 0) done2 = k;
         end
         if (k == 10) led_a = 8'h02;
         if (k == 30) led_a = 8'hFF;
      end
      n_checks++; if (n_done !== 2) $display("FAIL b2b_frames: got %0d want 2", n_done); else n_pass++;
      n_checks++; if (done1 !== 73) $display("FAIL b2b_done1: got %0d want 73", done1); else n_pass++;
      n_checks++; if (busy_after !== 1'b1) $display("FAIL b2b_restart: got busy %b want 1", busy_after); else n_pass++;
      n_checks++; if (done2 - done1 !== 73) $display("FAIL b2b_gap: got %0d want 73", done2 - done1); else n_pass++;
      n_checks++;
      if (obs_a.size() != exp_a.size()) $display("FAIL b2b_bit_count: got %0d want %0d", obs_a.size(), exp_a.size());
      else n_pass++;
      while (exp_a.size() > 0) begin
         e = exp_a.pop_front();
         o = 1'bx; if (obs_a.size() > 0) o = obs_a.pop_front();
         n_checks++; if (o !== e) $display("FAIL b2b_bit: got %b want %b", o, e); else n_pass++;
      end
      obs_a.delete();
   endtask

   task automatic test_reset_mid_frame();
      int waited = 0, done_at = -1;
      logic oe_bad = 1'b0;
      logic e, o;
      obs_a.delete();
      led_a = 8'hCB;
      while (obs_a.size() < 4 && waited < 200) begin @(negedge clk); waited++; end
      n_checks++; if (waited >= 200) $display("FAIL midrst_wait: got timeout want 4 bits"); else n_pass++;
      repeat (5) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({sck_a, sdat_a, lat_a, oen_a, busy_a, done_a} !== 6'b000100)
         $display("FAIL midrst_outputs: got %b want 000100", {sck_a, sdat_a, lat_a, oen_a, busy_a, done_a});
      else n_pass++;
      repeat (2) @(negedge clk);
      exp_a.delete(); obs_a.delete();
      push_exp_a(8'hCB);
      rst_a = 1'b0;
      for (int k = 1; k <= 120; k++) begin
         @(negedge clk);
         if (done_a && done_at < 0) done_at = k;
         if (done_at < 0 && !oen_a) oe_bad = 1'b1;
      end
      n_checks++; if (done_at !== 73) $display("FAIL midrst_done_at: got %0d want 73", done_at); else n_pass++;
      n_checks++; if (oe_bad !== 1'b0) $display("FAIL midrst_oe_early: got %b want 0", oe_bad); else n_pass++;
      n_checks++; if (oen_a !== 1'b0) $display("FAIL midrst_oe_after: got %b want 0", oen_a); else n_pass++;
      n_checks++;
      if (obs_a.size() != exp_a.size()) $display("FAIL midrst_bit_count: got %0d want %0d", obs_a.size(), exp_a.size());
      else n_pass++;
      while (exp_a.size() > 0) begin
         e = exp_a.pop_front();
         o = 1'bx; if (obs_a.size() > 0) o = obs_a.pop_front();
         n_checks++; if (o !== e) $display("FAIL midrst_bit: got %b want %b", o, e); else n_pass++;
      end
      obs_a.delete();
   endtask

   task automatic test_refresh();
      int starts[$];
      int exp_starts[$];
      logic prev_busy = 1'b0;
      exp_starts = '{1, 201, 401, 601, 701, 901};
      rst_b = 1'b1; led_b = 8'h55; frc_b = 1'b0;
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      for (int k = 1; k <= 1000; k++) begin
         @(negedge clk);
         if (busy_b && !prev_busy) starts.push_back(k);
         prev_busy = busy_b;
         if (k == 700) frc_b = 1'b1;
         if (k == 701) frc_b = 1'b0;
      end
      n_checks++;
      if (starts.size() != exp_starts.size()) $display("FAIL refresh_count: got %0d want %0d", starts.size(), exp_starts.size());
      else n_pass++;
      for (int i = 0; i < exp_starts.size(); i++) begin
         int got;
         got = (i < starts.size()) ? starts[i] : -1;
         n_checks++;
         if (got !== exp_starts[i]) $display("FAIL refresh_start[%0d]: got %0d want %0d", i, got, exp_starts[i]);
         else n_pass++;
      end
   endtask

   task automatic test_wide_fast();
      int n_busy = 0, done_at = -1, clk_err = 0;
      logic e, o;
      exp_c.delete(); obs_c.delete();
      push_exp_c(16'h8001);
      rst_c = 1'b1; led_c = 16'h8001;
      repeat (2) @(negedge clk);
      rst_c = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (busy_c) begin
            if (n_busy < 32 && sck_c !== n_busy[0]) clk_err++;
            n_busy++;
         end
         if (done_c && done_at < 0) done_at = k;
      end
      n_checks++; if (n_busy !== 34) $display("FAIL wide_busy_len: got %0d want 34", n_busy); else n_pass++;
      n_checks++; if (done_at !== 35) $display("FAIL wide_done_at: got %0d want 35", done_at); else n_pass++;
      n_checks++; if (clk_err !== 0) $display("FAIL wide_sck_toggle: got %0d errors want 0", clk_err); else n_pass++;
      n_checks++;
      if (obs_c.size() != exp_c.size()) $display("FAIL wide_bit_count: got %0d want %0d", obs_c.size(), exp_c.size());
      else n_pass++;
      while (exp_c.size() > 0) begin
         e = exp_c.pop_front();
         o = 1'bx; if (obs_c.size() > 0) o = obs_c.pop_front();
         n_checks++; if (o !== e) $display("FAIL wide_bit: got %b want %b", o, e); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_idle_change();
      test_back_to_back();
      test_reset_mid_frame();
      test_refresh();
      test_wide_fast();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/post_led_shifter.md
Name: post_led_shifter

Overview:
- Downstream stage of the POST/version LED mux.
- Takes the active-low LED byte `led_n` and serializes it into an external 74HC595-style shift-register chain that drives the front-panel/debug LEDs.
- A frame is sent when `led_n` changes, on a periodic refresh, or on a forced request.
- The chain's output-enable blanks the LEDs until the first complete frame has been latched.

Parameters:
- CHAIN_BITS, 8: width of `led_n` and length of the shift chain in bits; must be ≥1.
- CLK_DIV, 4: `sys_clk` cycles per half-period of `sr_clk`; must be ≥1.
- REFRESH_CYCLES, 1000000: `sys_clk` cycles between periodic re-sends; 0 disables periodic refresh.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- sys_rst  in  1  reset, synchronous and active-high.
- led_n  in  CHAIN_BITS  LED pattern to display, active-low, driven by the LED mux.
- force_refresh  in  1  one-cycle request to send a frame now.
- sr_clk  out  1  shift clock to the chain.
- sr_data  out  1  serial data to the chain, MSB first.
- sr_latch  out  1  storage-register latch strobe (RCLK).
- sr_oe_n  out  1  chain output enable, active-low.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values (while `sys_rst`=1):
  - `sr_clk`=0, `sr_data`=0, `sr_latch`=0, `sr_oe_n`=1, `busy`=0, `frame_done`=0.
  - Refresh counter = 0; pending = 1, so the first frame starts right after reset; `last_sent` = all ones.
- Reset asserted mid-frame aborts the frame immediately and returns `sr_oe_n` to 1.
- Trigger, evaluated every cycle: `trig` = pending | `force_refresh` | (`led_n` != `last_sent`) | (refresh counter == REFRESH_CYCLES-1 and REFRESH_CYCLES != 0).
- Simultaneous trigger sources produce exactly one frame.
- Refresh counter:
  - Free-running from 0 to REFRESH_CYCLES-1.
  - Restarts from 0 whenever a frame starts.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH_SETUP, LATCH.
  - Each non-IDLE state lasts CLK_DIV cycles, counted by a phase counter.
- IDLE:
  - `busy`=0.
  - If `trig` in cycle T:
    - Snapshot `led_n` into the shift register and `last_sent`.
    - Clear pending.
    - Enter SHIFT_LO at T+1 with bit index = CHAIN_BITS-1.
- SHIFT_LO:
  - `sr_clk`=0; `sr_data` = snapshot[bit index], stable for the whole state.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - `sr_clk`=1; `sr_data` held.
  - If bit index = 0, go to LATCH_SETUP; otherwise decrement the index and go to SHIFT_LO.
- LATCH_SETUP:
  - `sr_clk`=0, `sr_data`=0.
  - Then go to LATCH.
- LATCH:
  - `sr_latch`=1.
  - On exit, for one cycle: `frame_done`=1, `sr_latch`=0, `sr_oe_n`=0 (stays 0 until reset), and the FSM returns to IDLE.
- `busy`=1 in every non-IDLE state.
- Frame length is CHAIN_BITS*2*CLK_DIV + 2*CLK_DIV cycles; with defaults, `busy` is high for 72 cycles starting at T+1.
- The `frame_done` cycle is the first IDLE cycle. A trigger seen in that cycle starts the next frame at the following cycle (back-to-back frames allowed).
- `led_n` change or `force_refresh` while `busy`:
  - The snapshot is not disturbed.
  - Pending is set, so exactly one further frame follows, carrying the value of `led_n` at its own start.
  - Multiple changes during one frame collapse into one follow-up frame.
- A periodic refresh expiry while busy is ignored; the counter was already restarted at frame start.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=3'd0, SHIFT_LO=3'd1, SHIFT_HI=3'd2, LATCH_SETUP=3'd3, LATCH=3'd4.
  - Default CLK_DIV, CHAIN_BITS and REFRESH_CYCLES constants for reuse by other serial-LED drivers.
- One natural sub-module, `post_led_tick_div`: the parameterized phase/refresh counter, instantiated twice (CLK_DIV phase timer and REFRESH_CYCLES timer).
- The FSM and shift register stay in the top module.

Test Plan:
- Release reset with `led_n`=8'hA5 (defaults) -> frame starts the cycle after reset release:
  - `sr_data` sampled at each `sr_clk` rise reads 1,0,1,0,0,1,0,1.
  - `sr_latch` is high for 4 cycles; then `frame_done` pulses and `sr_oe_n` falls to 0.
  - `busy` is high for exactly 72 cycles.
- In IDLE, change `led_n` 8'hA5 -> 8'h3C -> exactly one frame shifting 0,0,1,1,1,1,0,0; no frame when `led_n` is held constant.
- Change `led_n` to 8'h01, then 8'h02, then 8'hFF during one frame -> the current frame completes unchanged, and exactly one follow-up frame carries 8'hFF, starting the cycle after `frame_done`.
- REFRESH_CYCLES=200, constant `led_n`=8'h55 -> a frame starts every 200 cycles, measured from the previous frame start; `force_refresh` pulsed in IDLE starts a frame the next cycle and resets the refresh count.
- Assert `sys_rst` at bit 3 of a frame -> next cycle `sr_clk`/`sr_data`/`sr_latch`/`busy`=0 and `sr_oe_n`=1; after release, a full frame is sent and `sr_oe_n` falls only after its latch.
- CLK_DIV=1, CHAIN_BITS=16, `led_n`=16'h8001 -> frame of 34 cycles; `sr_clk` toggles every cycle; the first and last shifted bits are 1 and all others 0.
